// File: rtl/controle_turno_pkg.sv
// Shared definitions for the turn controller: FSM encoding, player indices, parameter defaults.
package controle_turno_pkg;

    typedef enum logic [2:0] {
        OCIOSO,
        AGUARDA_TIRO,
        DISPARA,
        AGUARDA_COL,
        RESULTADO,
        FIM
    } estado_t;

    localparam logic JOGADOR_0 = 1'b0;
    localparam logic JOGADOR_1 = 1'b1;

    localparam int TOTAL_PECAS_PADRAO    = 17;
    localparam int TIMEOUT_CICLOS_PADRAO = 32;

endpackage

// File: rtl/historico_tiros.sv
// Per-player already-fired bitmap (256 cells indexed {y,x}); only built with CONTROLE_TURNO_HIST_EN.
// Lookup is combinational on the query coordinates; marking happens one cycle per shot.
`ifdef CONTROLE_TURNO_HIST_EN
module historico_tiros (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       mark,
    input  logic       jogador,
    input  logic [3:0] mark_x,
    input  logic [3:0] mark_y,
    input  logic [3:0] cons_x,
    input  logic [3:0] cons_y,
    output logic       ja_atirado
);
    logic [255:0] mapa_p0;
    logic [255:0] mapa_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mapa_p0 <= '0;
            mapa_p1 <= '0;
        end else if (clear) begin
            mapa_p0 <= '0;
            mapa_p1 <= '0;
        end else if (mark) begin
            if (jogador) mapa_p1[{mark_y, mark_x}] <= 1'b1;
            else         mapa_p0[{mark_y, mark_x}] <= 1'b1;
        end
    end

    assign ja_atirado = jogador ? mapa_p1[{cons_y, cons_x}] : mapa_p0[{cons_y, cons_x}];

endmodule
`endif

// File: rtl/controle_turno.sv
// Two-player turn controller: serialises shots through an external collision checker and keeps score.
// Define CONTROLE_TURNO_HIST_EN to reject repeat coordinates per player (historico_tiros).
module controle_turno
    import controle_turno_pkg::*;
#(
    parameter int TOTAL_PECAS    = TOTAL_PECAS_PADRAO,
    parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       tiro_valid,
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic       tiro_ready,
    output logic       col_enable,
    output logic       col_jogador,
    output logic [3:0] col_x,
    output logic [3:0] col_y,
    input  logic       col_ready,
    input  logic       col_hit,
    output logic       jogador_atual,
    output logic       resultado_valid,
    output logic       resultado_hit,
    output logic       erro,
    output logic [4:0] acertos_p0,
    output logic [4:0] acertos_p1,
    output logic       fim_jogo,
    output logic       vencedor
);
    localparam int            EW            = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [4:0]    TOTAL_W       = 5'(TOTAL_PECAS);
    localparam logic [EW-1:0] ULTIMA_ESPERA = EW'(TIMEOUT_CICLOS - 1);

    estado_t       estado, estado_prox;
    logic [EW-1:0] espera;
    logic          hit_reg;
    logic          repetido;
    logic          aceita_start;
    logic          col_amostra;
    logic          estouro;
    logic          fim_agora;
    logic [4:0]    cont_atual;
    logic [4:0]    cont_novo;

    assign aceita_start = start && (estado == OCIOSO || estado == FIM);
    // espera==0 is the first AGUARDA_COL cycle, where col_ready is not trusted yet
    assign col_amostra  = (estado == AGUARDA_COL) && (espera != '0) && col_ready;
    assign estouro      = (estado == AGUARDA_COL) && !col_amostra && (espera == ULTIMA_ESPERA);
    assign cont_atual   = (jogador_atual == JOGADOR_1) ? acertos_p1 : acertos_p0;
    assign cont_novo    = (hit_reg && cont_atual < TOTAL_W) ? cont_atual + 5'd1 : cont_atual;
    assign fim_agora    = (cont_novo == TOTAL_W);

`ifdef CONTROLE_TURNO_HIST_EN
    historico_tiros u_hist (
        .clk        (clk),
        .reset      (reset),
        .clear      (aceita_start),
        .mark       (estado == DISPARA),
        .jogador    (jogador_atual),
        .mark_x     (col_x),
        .mark_y     (col_y),
        .cons_x     (x),
        .cons_y     (y),
        .ja_atirado (repetido)
    );
`else
    assign repetido = 1'b0;
`endif

    always_comb begin
        estado_prox     = estado;
        tiro_ready      = 1'b0;
        col_enable      = 1'b0;
        col_jogador     = 1'b0;
        resultado_valid = 1'b0;
        resultado_hit   = 1'b0;
        case (estado)
            OCIOSO, FIM: if (start) estado_prox = AGUARDA_TIRO;
            AGUARDA_TIRO: begin
                tiro_ready = 1'b1;
                if (tiro_valid && !repetido) estado_prox = DISPARA;
            end
            DISPARA: begin
                col_enable  = 1'b1;
                col_jogador = jogador_atual;
                estado_prox = AGUARDA_COL;
            end
            AGUARDA_COL: begin
                col_enable  = 1'b1;
                col_jogador = jogador_atual;
                if (col_amostra || estouro) estado_prox = RESULTADO;
            end
            RESULTADO: begin
                resultado_valid = 1'b1;
                resultado_hit   = hit_reg;
                estado_prox     = fim_agora ? FIM : AGUARDA_TIRO;
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado        <= OCIOSO;
            espera        <= '0;
            hit_reg       <= 1'b0;
            col_x         <= '0;
            col_y         <= '0;
            jogador_atual <= JOGADOR_0;
            erro          <= 1'b0;
            acertos_p0    <= '0;
            acertos_p1    <= '0;
            fim_jogo      <= 1'b0;
            vencedor      <= 1'b0;
        end else begin
            estado <= estado_prox;
            erro   <= 1'b0;
            case (estado)
                OCIOSO, FIM: if (start) begin
                    acertos_p0    <= '0;
                    acertos_p1    <= '0;
                    fim_jogo      <= 1'b0;
                    vencedor      <= 1'b0;
                    jogador_atual <= JOGADOR_0;
                end
                AGUARDA_TIRO: if (tiro_valid) begin
                    if (repetido) begin
                        erro <= 1'b1;
                    end else begin
                        col_x <= x;
                        col_y <= y;
                    end
                end
                DISPARA: espera <= '0;
                AGUARDA_COL: begin
                    espera <= espera + 1'b1;
                    if (col_amostra) begin
                        hit_reg <= col_hit;
                    end else if (estouro) begin
                        hit_reg <= 1'b0;
                        erro    <= 1'b1;
                    end
                end
                RESULTADO: begin
                    if (jogador_atual == JOGADOR_1) acertos_p1 <= cont_novo;
                    else                            acertos_p0 <= cont_novo;
                    if (fim_agora) begin
                        fim_jogo <= 1'b1;
                        vencedor <= jogador_atual;
                    end else if (!hit_reg) begin
                        jogador_atual <= ~jogador_atual;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controle_turno.sv
// Self-checking bench for controle_turno: directed scenarios plus randomized shots against a turn-level model.
module tb_controle_turno;
    localparam int TOTAL = 2;
    localparam int TMO   = 32;

    logic       clk = 1'b0;
    logic       reset, start, tiro_valid, col_ready, col_hit;
    logic [3:0] x, y, col_x, col_y;
    logic       tiro_ready, col_enable, col_jogador, jogador_atual;
    logic       resultado_valid, resultado_hit, erro, fim_jogo, vencedor;
    logic [4:0] acertos_p0, acertos_p1;

    int n_cmp = 0;
    int n_err = 0;

    // turn-level reference model
    int m_acc [2];
    int m_jog;
    bit m_fim;
    int m_venc;
    bit fired [2][256];

    always #5 clk = ~clk;

    controle_turno #(.TOTAL_PECAS(TOTAL), .TIMEOUT_CICLOS(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .tiro_valid(tiro_valid), .x(x), .y(y),
        .tiro_ready(tiro_ready), .col_enable(col_enable), .col_jogador(col_jogador),
        .col_x(col_x), .col_y(col_y), .col_ready(col_ready), .col_hit(col_hit),
        .jogador_atual(jogador_atual), .resultado_valid(resultado_valid),
        .resultado_hit(resultado_hit), .erro(erro), .acertos_p0(acertos_p0),
        .acertos_p1(acertos_p1), .fim_jogo(fim_jogo), .vencedor(vencedor)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_acc[0] = 0; m_acc[1] = 0; m_jog = 0; m_fim = 0; m_venc = 0;
        for (int p = 0; p < 2; p++) for (int c = 0; c < 256; c++) fired[p][c] = 0;
    endtask

    // Outcome of one shot given the checker's response cycle (counted from col_enable rising).
    task automatic model_expect(input int lat, input logic h, output int ek, output int ee, output logic eh);
        if (lat >= 2 && lat <= TMO) begin
            ek = lat + 1; ee = -1; eh = h;
        end else begin
            ek = TMO + 1; ee = TMO + 1; eh = 1'b0;
        end
    endtask

    task automatic model_apply(input logic eh);
        if (eh) m_acc[m_jog]++;
        if (m_acc[m_jog] == TOTAL) begin
            m_fim = 1; m_venc = m_jog;
        end else if (!eh) begin
            m_jog = 1 - m_jog;
        end
    endtask

    task automatic begin_game();
        reset = 1'b1; tick(); reset = 1'b0; tick();
        start = 1'b1; tick(); start = 1'b0;
        model_clear();
    endtask

    // Drives one shot and a checker that pulses col_ready at cycle 'lat' (DISPARA = 0); lat<0 never answers.
    task automatic shot(input logic [3:0] sx, input logic [3:0] sy, input int lat, input logic h,
                        output logic acc, output int k_res, output int k_erro, output logic hit_obs,
                        output logic en_ok, output logic [3:0] cx, output logic [3:0] cy, output logic cj);
        int w = 0;
        acc = 0; k_res = -1; k_erro = -1; hit_obs = 0; en_ok = 1; cx = 0; cy = 0; cj = 0;
        while (tiro_ready !== 1'b1 && w < 50) begin tick(); w++; end
        if (tiro_ready !== 1'b1) return;
        acc = 1;
        tiro_valid = 1'b1; x = sx; y = sy;
        tick();
        tiro_valid = 1'b0; x = 4'($urandom); y = 4'($urandom);
        cx = col_x; cy = col_y; cj = col_jogador;
        for (int k = 0; k < 60 && k_res < 0; k++) begin
            if (resultado_valid === 1'b1) begin
                k_res = k; hit_obs = resultado_hit;
                if (col_enable !== 1'b0) en_ok = 0;
            end else if (col_enable !== 1'b1) begin
                en_ok = 0;
            end
            if (erro === 1'b1 && k_erro < 0) k_erro = k;
            col_ready = (k == lat);
            col_hit   = (k == lat) ? h : 1'($urandom);
            tick();
        end
        col_ready = 1'b0; col_hit = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; tiro_valid = 1'b0; x = 0; y = 0; col_ready = 0; col_hit = 0;
        tick(); tick();
        n_cmp++; if ({tiro_ready, col_enable, col_jogador, resultado_valid, resultado_hit, erro, fim_jogo, vencedor, jogador_atual} !== 9'b0) begin
            n_err++; $display("FAIL reset_flags: got %b want 0", {tiro_ready, col_enable, col_jogador, resultado_valid, resultado_hit, erro, fim_jogo, vencedor, jogador_atual});
        end
        n_cmp++; if ({acertos_p0, acertos_p1, col_x, col_y} !== 18'b0) begin
            n_err++; $display("FAIL reset_regs: got %h want 0", {acertos_p0, acertos_p1, col_x, col_y});
        end
        reset = 1'b0; tiro_valid = 1'b1; tick(); tick();
        n_cmp++; if (tiro_ready !== 1'b0 || col_enable !== 1'b0) begin
            n_err++; $display("FAIL idle_ignores_tiro: ready=%b en=%b want 0 0", tiro_ready, col_enable);
        end
        tiro_valid = 1'b0;
    endtask

    task automatic test_basic_miss();
        logic acc, ho, en; int kr, ke; logic [3:0] cx, cy; logic cj;
        begin_game();
        n_cmp++; if (tiro_ready !== 1'b1 || jogador_atual !== 1'b0) begin
            n_err++; $display("FAIL start_state: ready=%b jog=%b want 1 0", tiro_ready, jogador_atual);
        end
        shot(4'd3, 4'd4, 12, 1'b0, acc, kr, ke, ho, en, cx, cy, cj);
        n_cmp++; if ({acc, cx, cy, cj} !== {1'b1, 4'd3, 4'd4, 1'b0}) begin
            n_err++; $display("FAIL miss_launch: got acc=%b x=%0d y=%0d j=%b want 1 3 4 0", acc, cx, cy, cj);
        end
        n_cmp++; if (kr !== 13 || ho !== 1'b0 || ke !== -1 || en !== 1'b1) begin
            n_err++; $display("FAIL miss_result: got k=%0d hit=%b erro_k=%0d en=%b want 13 0 -1 1", kr, ho, ke, en);
        end
        n_cmp++; if (jogador_atual !== 1'b1 || acertos_p0 !== 5'd0) begin
            n_err++; $display("FAIL miss_turn: got jog=%b acc0=%0d want 1 0", jogador_atual, acertos_p0);
        end
        model_apply(1'b0);
    endtask

    task automatic test_hit_keeps_turn();
        logic acc, ho, en; int kr, ke; logic [3:0] cx, cy; logic cj;
        int lat = 2 + int'($urandom_range(0, 9));
        shot(4'd5, 4'd5, lat, 1'b1, acc, kr, ke, ho, en, cx, cy, cj);
        n_cmp++; if (cj !== 1'b1 || kr !== lat + 1 || ho !== 1'b1) begin
            n_err++; $display("FAIL hit_result: got j=%b k=%0d hit=%b want 1 %0d 1", cj, kr, ho, lat + 1);
        end
        n_cmp++; if (acertos_p1 !== 5'd1 || jogador_atual !== 1'b1) begin
            n_err++; $display("FAIL hit_turn: got acc1=%0d jog=%b want 1 1", acertos_p1, jogador_atual);
        end
        start = 1'b1; tick(); start = 1'b0; tick();
        n_cmp++; if (acertos_p1 !== 5'd1 || tiro_ready !== 1'b1) begin
            n_err++; $display("FAIL start_ignored: got acc1=%0d ready=%b want 1 1", acertos_p1, tiro_ready);
        end
        model_apply(1'b1);
        shot(4'd6, 4'd6, 4, 1'b0, acc, kr, ke, ho, en, cx, cy, cj);
        n_cmp++; if (acc !== 1'b1 || cj !== 1'b1 || jogador_atual !== 1'b0) begin
            n_err++; $display("FAIL reshot: got acc=%b j=%b jog_after=%b want 1 1 0", acc, cj, jogador_atual);
        end
        model_apply(1'b0);
    endtask

    task automatic test_timeout();
        logic acc, ho, en; int kr, ke; logic [3:0] cx, cy; logic cj;
        shot(4'd1, 4'd1, -1, 1'b0, acc, kr, ke, ho, en, cx, cy, cj);
        n_cmp++; if (ke !== TMO + 1 || kr !== TMO + 1 || ho !== 1'b0 || en !== 1'b1) begin
            n_err++; $display("FAIL timeout: got erro_k=%0d k=%0d hit=%b en=%b want 33 33 0 1", ke, kr, ho, en);
        end
        n_cmp++; if (erro !== 1'b0 || jogador_atual !== 1'b1) begin
            n_err++; $display("FAIL timeout_after: got erro=%b jog=%b want 0 1", erro, jogador_atual);
        end
        model_apply(1'b0);
        shot(4'd2, 4'd2, 1, 1'b1, acc, kr, ke, ho, en, cx, cy, cj);
        n_cmp++; if (kr !== TMO + 1 || ke !== TMO + 1 || ho !== 1'b0 || acertos_p1 !== 5'd1 || jogador_atual !== 1'b0) begin
            n_err++; $display("FAIL early_ready: got k=%0d erro_k=%0d hit=%b acc1=%0d jog=%b want 33 33 0 1 0", kr, ke, ho, acertos_p1, jogador_atual);
        end
        model_apply(1'b0);
        shot(4'd3, 4'd3, TMO, 1'b1, acc, kr, ke, ho, en, cx, cy, cj);
        n_cmp++; if (kr !== TMO + 1 || ke !== -1 || ho !== 1'b1 || acertos_p0 !== 5'd1 || jogador_atual !== 1'b0) begin
            n_err++; $display("FAIL last_cycle_ready: got k=%0d erro_k=%0d hit=%b acc0=%0d jog=%b want 33 -1 1 1 0", kr, ke, ho, acertos_p0, jogador_atual);
        end
        model_apply(1'b1);
    endtask

    task automatic test_game_over();
        logic acc, ho, en; int kr, ke; logic [3:0] cx, cy; logic cj; bit leak = 0;
        begin_game();
        shot(4'd0, 4'd0, 3, 1'b1, acc, kr, ke, ho, en, cx, cy, cj);
        shot(4'd0, 4'd1, 5, 1'b1, acc, kr, ke, ho, en, cx, cy, cj);
        n_cmp++; if (fim_jogo !== 1'b1 || vencedor !== 1'b0 || acertos_p0 !== 5'd2) begin
            n_err++; $display("FAIL game_over: got fim=%b venc=%b acc0=%0d want 1 0 2", fim_jogo, vencedor, acertos_p0);
        end
        tiro_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (tiro_ready !== 1'b0 || col_enable !== 1'b0) leak = 1;
            tick();
        end
        tiro_valid = 1'b0;
        n_cmp++; if (leak || fim_jogo !== 1'b1 || acertos_p0 !== 5'd2) begin
            n_err++; $display("FAIL fim_hold: got leak=%0d fim=%b acc0=%0d want 0 1 2", leak, fim_jogo, acertos_p0);
        end
        start = 1'b1; tick(); start = 1'b0;
        n_cmp++; if ({fim_jogo, vencedor, jogador_atual, tiro_ready} !== 4'b0001 || acertos_p0 !== 5'd0) begin
            n_err++; $display("FAIL restart: got fvjr=%b acc0=%0d want 0001 0", {fim_jogo, vencedor, jogador_atual, tiro_ready}, acertos_p0);
        end
    endtask

    task automatic test_reset_mid_shot();
        logic acc, ho, en; int kr, ke; logic [3:0] cx, cy; logic cj;
        begin_game();
        shot(4'd9, 4'd9, 2, 1'b1, acc, kr, ke, ho, en, cx, cy, cj);
        tiro_valid = 1'b1; x = 4'd10; y = 4'd11; tick();
        tiro_valid = 1'b0; tick(); tick();
        n_cmp++; if (col_enable !== 1'b1) begin
            n_err++; $display("FAIL pre_reset_enable: got %b want 1", col_enable);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({col_enable, col_jogador, tiro_ready, jogador_atual, fim_jogo, erro} !== 6'b0 || {acertos_p0, col_x, col_y} !== 13'b0) begin
            n_err++; $display("FAIL async_reset: got %b %h want 0 0", {col_enable, col_jogador, tiro_ready, jogador_atual, fim_jogo, erro}, {acertos_p0, col_x, col_y});
        end
        #2 reset = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        model_clear();
        shot(4'd9, 4'd9, 4, 1'b0, acc, kr, ke, ho, en, cx, cy, cj);
        n_cmp++; if (acc !== 1'b1 || kr !== 5 || jogador_atual !== 1'b1) begin
            n_err++; $display("FAIL post_reset_game: got acc=%b k=%0d jog=%b want 1 5 1", acc, kr, jogador_atual);
        end
        model_apply(1'b0);
    endtask

    task automatic test_random();
        logic acc, ho, en; int kr, ke; logic [3:0] cx, cy; logic cj;
        int ek, ee, lat, sj, c; logic eh, h;
        begin_game();
        for (int i = 0; i < 40; i++) begin
            if (m_fim) begin
                start = 1'b1; tick(); start = 1'b0;
                model_clear();
            end
            do c = int'($urandom_range(0, 255)); while (fired[m_jog][c]);
            fired[m_jog][c] = 1;
            lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 34));
            h = 1'($urandom);
            sj = m_jog;
            model_expect(lat, h, ek, ee, eh);
            shot(4'(c), 4'(c >> 4), lat, h, acc, kr, ke, ho, en, cx, cy, cj);
            model_apply(eh);
            n_cmp++; if (acc !== 1'b1 || cj !== 1'(sj) || cx !== 4'(c) || cy !== 4'(c >> 4)) begin
                n_err++; $display("FAIL rnd_launch[%0d]: got acc=%b j=%b x=%0d y=%0d want 1 %0d %0d %0d", i, acc, cj, cx, cy, sj, c % 16, c / 16);
            end
            n_cmp++; if (kr !== ek || ke !== ee || ho !== eh || en !== 1'b1) begin
                n_err++; $display("FAIL rnd_result[%0d]: got k=%0d erro_k=%0d hit=%b en=%b want %0d %0d %b 1 (lat=%0d)", i, kr, ke, ho, en, ek, ee, eh, lat);
            end
            n_cmp++; if (acertos_p0 !== 5'(m_acc[0]) || acertos_p1 !== 5'(m_acc[1]) || jogador_atual !== 1'(m_jog)) begin
                n_err++; $display("FAIL rnd_score[%0d]: got %0d %0d jog=%b want %0d %0d %0d", i, acertos_p0, acertos_p1, jogador_atual, m_acc[0], m_acc[1], m_jog);
            end
            n_cmp++; if (fim_jogo !== m_fim || (m_fim && vencedor !== 1'(m_venc))) begin
                n_err++; $display("FAIL rnd_fim[%0d]: got fim=%b venc=%b want %b %0d", i, fim_jogo, vencedor, m_fim, m_venc);
            end
        end
    endtask

`ifdef CONTROLE_TURNO_HIST_EN
    task automatic test_historico();
        logic acc, ho, en; int kr, ke; logic [3:0] cx, cy; logic cj;
        begin_game();
        shot(4'd7, 4'd2, 3, 1'b0, acc, kr, ke, ho, en, cx, cy, cj);
        shot(4'd9, 4'd9, 3, 1'b0, acc, kr, ke, ho, en, cx, cy, cj);
        tiro_valid = 1'b1; x = 4'd7; y = 4'd2;
        n_cmp++; if (tiro_ready !== 1'b1 || jogador_atual !== 1'b0) begin
            n_err++; $display("FAIL hist_pre: got ready=%b jog=%b want 1 0", tiro_ready, jogador_atual);
        end
        tick(); tiro_valid = 1'b0;
        n_cmp++; if (erro !== 1'b1 || col_enable !== 1'b0 || tiro_ready !== 1'b1) begin
            n_err++; $display("FAIL hist_repeat: got erro=%b en=%b ready=%b want 1 0 1", erro, col_enable, tiro_ready);
        end
        tick();
        n_cmp++; if (erro !== 1'b0 || col_enable !== 1'b0 || jogador_atual !== 1'b0) begin
            n_err++; $display("FAIL hist_after: got erro=%b en=%b jog=%b want 0 0 0", erro, col_enable, jogador_atual);
        end
        shot(4'd8, 4'd2, 3, 1'b0, acc, kr, ke, ho, en, cx, cy, cj);
        n_cmp++; if (acc !== 1'b1 || cj !== 1'b0 || kr !== 4) begin
            n_err++; $display("FAIL hist_new: got acc=%b j=%b k=%0d want 1 0 4", acc, cj, kr);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_miss();
        test_hit_keeps_turn();
        test_timeout();
        test_game_over();
        test_reset_mid_shot();
`ifdef CONTROLE_TURNO_HIST_EN
        test_historico();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
